// File: rtl/regfile_pkg.sv
// Shared types, default sizes and address-wrap helper for the register-file readout block.
package regfile_pkg;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = $clog2(NUM_REGS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Register index arithmetic wraps modulo NUM_REGS (a power of two).
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] step);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'(NUM_REGS - 1);
        return (addr + step) & mask;
    endfunction

endpackage

// File: rtl/regfile_readout_if.sv
// Control, register-file read port and output stream bundle of the readout block.
interface regfile_readout_if #(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int CNT_W  = regfile_pkg::CNT_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              abort;
    logic [ADDR_W-1:0] rf_rs;
    logic [ADDR_W-1:0] rf_rt;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, count, abort, rf_a, rf_b, out_ready,
        output rf_rs, rf_rt, out_valid, out_data, out_addr, busy, done
    );

    modport slave (
        output start, base_addr, count, abort, rf_a, rf_b, out_ready,
        input  rf_rs, rf_rt, out_valid, out_data, out_addr, busy, done
    );
endinterface

// File: rtl/regfile_readout_buf.sv
// Two-entry capture buffer: snapshots both read ports, then presents entry 0 or 1
// on a registered output that only moves on capture or advance.
module regfile_readout_buf #(
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              advance,
    input  logic [DATA_W-1:0] rd_a,
    input  logic [DATA_W-1:0] rd_b,
    output logic              idx,
    output logic [DATA_W-1:0] data
);
    import regfile_pkg::*;

    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              idx_q, idx_d;

    // Next buffer contents and selected word.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        idx_d  = idx_q;
        data_d = data_q;
        if (capture) begin
            buf0_d = rd_a;
            buf1_d = rd_b;
            idx_d  = 1'b0;
            data_d = rd_a;
        end else if (advance) begin
            idx_d  = 1'b1;
            data_d = buf1_q;
        end else begin
            data_d = data_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_q <= {DATA_W{1'b0}};
            buf1_q <= {DATA_W{1'b0}};
            idx_q  <= 1'b0;
            data_q <= {DATA_W{1'b0}};
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign idx  = idx_q;
    assign data = data_q;

endmodule

// File: rtl/regfile_readout.sv
// Bulk register-file reader: fetches two registers per FETCH cycle through the rs/rt
// read ports and streams them out one word per valid/ready handshake.
module regfile_readout #(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int CNT_W    = regfile_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_readout_if.master bus
);
    import regfile_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] rf_rs_q, rf_rs_d;
    logic [ADDR_W-1:0] rf_rt_q, rf_rt_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              capture_s;
    logic              advance_s;
    logic              handshake_s;
    logic              idx_s;
    logic [DATA_W-1:0] out_data_s;
    logic [CNT_W-1:0]  count_clamped_s;
    logic [ADDR_W-1:0] base_wrapped_s;

    regfile_readout_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (capture_s),
        .advance (advance_s),
        .rd_a    (bus.rf_a),
        .rd_b    (bus.rf_b),
        .idx     (idx_s),
        .data    (out_data_s)
    );

    // Clamp the requested length and fold the base into the register range.
    always_comb begin
        if (bus.count > CNT_W'(NUM_REGS)) begin
            count_clamped_s = CNT_W'(NUM_REGS);
        end else begin
            count_clamped_s = bus.count;
        end
        base_wrapped_s = addr_inc(bus.base_addr, {ADDR_W{1'b0}});
        handshake_s    = out_valid_q & bus.out_ready;
    end

    // Next-state and registered-output logic of the dump sequencer.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        rf_rs_d     = rf_rs_q;
        rf_rt_d     = rf_rt_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        capture_s   = 1'b0;
        advance_s   = 1'b0;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (bus.start) begin
                    cur_d = base_wrapped_s;
                    rem_d = count_clamped_s;
                    if (count_clamped_s == {CNT_W{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        rf_rs_d = base_wrapped_s;
                        rf_rt_d = addr_inc(base_wrapped_s, ADDR_W'(1));
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (bus.abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    capture_s   = 1'b1;
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                    out_addr_d  = cur_q;
                end
            end
            SEND: begin
                // abort wins over a same-cycle handshake
                if (bus.abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else if (handshake_s) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                    end else if (!idx_s) begin
                        advance_s  = 1'b1;
                        out_addr_d = addr_inc(cur_q, ADDR_W'(1));
                    end else begin
                        cur_d       = addr_inc(cur_q, ADDR_W'(2));
                        state_d     = FETCH;
                        out_valid_d = 1'b0;
                        rf_rs_d     = addr_inc(cur_q, ADDR_W'(2));
                        rf_rt_d     = addr_inc(cur_q, ADDR_W'(3));
                    end
                end else begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= {ADDR_W{1'b0}};
            rem_q       <= {CNT_W{1'b0}};
            rf_rs_q     <= {ADDR_W{1'b0}};
            rf_rt_q     <= {ADDR_W{1'b0}};
            out_addr_q  <= {ADDR_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            rf_rs_q     <= rf_rs_d;
            rf_rt_q     <= rf_rt_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rf_rs     = rf_rs_q;
    assign bus.rf_rt     = rf_rt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_s;
    assign bus.out_addr  = out_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_regfile_readout.sv
// Scoreboard bench for regfile_readout: stimulus pushes hand-computed words, a negedge
// monitor pops and compares on every accepted word.
module tb_regfile_readout;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [31:0] rf_mem [8];
    exp_t exp_q [$];

    int checks;
    int errors;
    int done_cnt;
    int fetch_cnt;
    int hs_cnt;
    logic [4:0] last_rs;
    logic [4:0] last_rt;

    regfile_readout_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(4)) bus ();

    regfile_readout dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.rf_a = rf_mem[bus.rf_rs[2:0]];
    assign bus.rf_b = rf_mem[bus.rf_rt[2:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Monitor: counts done pulses / fetch cycles and checks accepted words.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.done) done_cnt++;
            if (bus.busy && !bus.out_valid && !bus.done) begin
                fetch_cnt++;
                last_rs = bus.rf_rs;
                last_rt = bus.rf_rt;
            end
            if (bus.out_valid && bus.out_ready && !bus.abort) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got addr=%0d data=%0d, none expected",
                             bus.out_addr, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_addr !== e.addr || bus.out_data !== e.data) begin
                        errors++;
                        $display("FAIL word got addr=%0d data=%0d expected addr=%0d data=%0d",
                                 bus.out_addr, bus.out_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic start_dump(input logic [4:0] b, input logic [3:0] c);
        done_cnt  = 0;
        fetch_cnt = 0;
        hs_cnt    = 0;
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.count     = c;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!bus.busy && exp_q.size() == 0) break;
        end
        checks++;
        if (bus.busy || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got busy=%0d pending=%0d expected busy=0 pending=0",
                     name, bus.busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        checks = 0; errors = 0; done_cnt = 0; fetch_cnt = 0; hs_cnt = 0;
        last_rs = 5'd0; last_rt = 5'd0;
        rf_mem = '{32'd1, 32'd2, 32'd0, 32'd5, 32'd1, 32'd1, 32'd0, 32'd1};
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base_addr = 5'd0; bus.count = 4'd0;
        bus.abort = 1'b0; bus.out_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_addr", {27'd0, bus.out_addr}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_rf_rs", {27'd0, bus.rf_rs}, 32'd0);
        chk("rst_rf_rt", {27'd0, bus.rf_rt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full dump with first-valid latency
        push(5'd0, 32'd1); push(5'd1, 32'd2); push(5'd2, 32'd0); push(5'd3, 32'd5);
        push(5'd4, 32'd1); push(5'd5, 32'd1); push(5'd6, 32'd0); push(5'd7, 32'd1);
        start_dump(5'd0, 4'd8);
        chk("full_fetch_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("full_fetch_rs", {27'd0, bus.rf_rs}, 32'd0);
        chk("full_fetch_rt", {27'd0, bus.rf_rt}, 32'd1);
        chk("full_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("full_first_valid", {31'd0, bus.out_valid}, 32'd1);
        wait_idle("full");
        chk("full_done_cnt", done_cnt, 32'd1);
        chk("full_fetch_cnt", fetch_cnt, 32'd4);

        // Wrap with odd count
        push(5'd6, 32'd0); push(5'd7, 32'd1); push(5'd0, 32'd1);
        start_dump(5'd6, 4'd3);
        wait_idle("wrap");
        chk("wrap_fetch_cnt", fetch_cnt, 32'd2);
        chk("wrap_last_rs", {27'd0, last_rs}, 32'd0);
        chk("wrap_last_rt", {27'd0, last_rt}, 32'd1);
        chk("wrap_done_cnt", done_cnt, 32'd1);

        // Backpressure: word held stable through five stalled cycles
        bus.out_ready = 1'b0;
        push(5'd1, 32'd2); push(5'd2, 32'd0);
        start_dump(5'd1, 4'd2);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_data", bus.out_data, 32'd2);
            chk("stall_addr", {27'd0, bus.out_addr}, 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_idle("stall");
        chk("stall_done_cnt", done_cnt, 32'd1);

        // Zero count: done one cycle after start, no words
        start_dump(5'd3, 4'd0);
        chk("zero_done", {31'd0, bus.done}, 32'd1);
        chk("zero_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_idle("zero");
        chk("zero_done_cnt", done_cnt, 32'd1);

        // Clamp: count 15 gives 8 words
        push(5'd0, 32'd1); push(5'd1, 32'd2); push(5'd2, 32'd0); push(5'd3, 32'd5);
        push(5'd4, 32'd1); push(5'd5, 32'd1); push(5'd6, 32'd0); push(5'd7, 32'd1);
        start_dump(5'd0, 4'd15);
        wait_idle("clamp");
        chk("clamp_words", hs_cnt, 32'd8);
        chk("clamp_done_cnt", done_cnt, 32'd1);

        // Abort after third handshake, then restart
        push(5'd0, 32'd1); push(5'd1, 32'd2); push(5'd2, 32'd0);
        start_dump(5'd0, 4'd8);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (hs_cnt >= 3) break;
        end
        chk("abort_reach_hs3", hs_cnt, 32'd3);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) tick();
        chk("abort_done_cnt", done_cnt, 32'd0);
        push(5'd2, 32'd0); push(5'd3, 32'd5);
        start_dump(5'd2, 4'd2);
        wait_idle("restart");
        chk("restart_done_cnt", done_cnt, 32'd1);

        // Snapshot: write to reg1 after its fetch is not reflected
        bus.out_ready = 1'b0;
        push(5'd0, 32'd1); push(5'd1, 32'd2);
        start_dump(5'd0, 4'd2);
        tick();
        rf_mem[1] = 32'd9;
        repeat (2) tick();
        bus.out_ready = 1'b1;
        wait_idle("snap");
        rf_mem[1] = 32'd2;

        // Reset asserted mid-SEND
        bus.out_ready = 1'b0;
        start_dump(5'd0, 4'd8);
        tick();
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        chk("mid_rst_addr", {27'd0, bus.out_addr}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_rs", {27'd0, bus.rf_rs}, 32'd0);
        chk("mid_rst_rt", {27'd0, bus.rf_rt}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) tick();
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_rst_done_cnt", done_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
